// File: rtl/tunnel_wall_gen.sv
// Scrolling tunnel wall generator: ring buffer of per-row left edges at 4x-scaled
// resolution, random-walk fill of the new top row, per-pixel wall code and bot collision.
module tunnel_wall_gen #(
   parameter int ROWS         = 120,
   parameter int COLS         = 160,
   parameter int INIT_GAP     = 64,
   parameter int MIN_GAP      = 24,
   parameter int NARROW_EVERY = 16
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [9:0] pixel_row,
   input  logic [9:0] pixel_column,
   input  logic       video_on,
   input  logic [7:0] rand_val,
   input  logic       scroll_en,
   input  logic [1:0] speed,
   input  logic       restart,
   input  logic [6:0] bot_row,
   input  logic [7:0] bot_col,
   output logic [1:0] wall,
   output logic       collide,
   output logic       ready,
   output logic       scroll_tick
);

   localparam int PTR_W = $clog2(ROWS);

   localparam logic [PTR_W-1:0]  LAST_ROW    = PTR_W'(ROWS - 1);
   localparam logic [PTR_W:0]    ROWS_EXT    = (PTR_W + 1)'(ROWS);
   localparam logic [7:0]        ROWS_B      = 8'(ROWS);
   localparam logic [7:0]        INIT_LEFT   = 8'((COLS - INIT_GAP) / 2);
   localparam logic [7:0]        GAP_INIT    = 8'(INIT_GAP);
   localparam logic [7:0]        GAP_MIN     = 8'(MIN_GAP);
   localparam logic [7:0]        NARROW_LAST = 8'(NARROW_EVERY - 1);
   localparam logic signed [8:0] COL_LAST    = 9'(COLS - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_STEP
   } state_t;

   // Offset into the ring; sum is always below 2*ROWS so one subtract suffices.
   function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
      logic [PTR_W:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= ROWS_EXT) begin
         sum = sum - ROWS_EXT;
      end
      return sum[PTR_W-1:0];
   endfunction

   function automatic logic [1:0] classify(input logic [7:0] cs,
                                           input logic [7:0] left,
                                           input logic [7:0] gap);
      logic signed [9:0] c;
      logic signed [9:0] lm1;
      logic signed [9:0] rp;
      c   = $signed({2'b00, cs});
      lm1 = $signed({2'b00, left}) - 10'sd1;
      rp  = $signed({2'b00, left}) + $signed({2'b00, gap});
      if ((c == lm1) || (c == rp)) begin
         return 2'b10;
      end else if ((c < lm1) || (c > rp)) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic [7:0] step_edge(input logic [7:0] prev,
                                            input logic [1:0] sel,
                                            input logic [7:0] gap);
      logic signed [8:0] delta;
      logic signed [8:0] sum;
      logic signed [8:0] hi;
      case (sel)
         2'b00:   delta = -9'sd1;
         2'b10:   delta = 9'sd1;
         default: delta = 9'sd0;
      endcase
      sum = $signed({1'b0, prev}) + delta;
      hi  = COL_LAST - $signed({1'b0, gap});
      if (sum < 9'sd1) begin
         sum = 9'sd1;
      end else if (sum > hi) begin
         sum = hi;
      end
      return sum[7:0];
   endfunction

   logic [7:0] left_edge [ROWS];

   state_t           state_q, state_d;
   logic [PTR_W-1:0] init_idx_q, init_idx_d;
   logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
   logic [7:0]       gap_q, gap_d;
   logic [1:0]       frame_cnt_q, frame_cnt_d;
   logic [7:0]       narrow_cnt_q, narrow_cnt_d;
   logic             ready_q, ready_d;
   logic [9:0]       row_prev_q;
   logic             frame_end_q;
   logic [1:0]       wall_q, wall_d;
   logic             collide_q, collide_d;

   logic             mem_we;
   logic [PTR_W-1:0] mem_waddr;
   logic [7:0]       mem_wdata;
   logic             tick;

   logic [PTR_W-1:0] top_dec;
   logic [7:0]       step_val;
   logic [7:0]       rs;
   logic [7:0]       cs;
   logic             rs_ok;
   logic [PTR_W-1:0] pix_addr;
   logic [7:0]       pix_left;
   logic             bot_ok;
   logic [PTR_W-1:0] bot_addr;
   logic [7:0]       bot_left;
   logic             unused_bits;

   assign top_dec  = (top_ptr_q == '0) ? LAST_ROW : top_ptr_q - 1'b1;
   assign step_val = step_edge(left_edge[top_ptr_q], rand_val[1:0], gap_q);

   assign rs       = pixel_row[9:2];
   assign cs       = pixel_column[9:2];
   assign rs_ok    = rs < ROWS_B;
   assign pix_addr = ring_add(top_ptr_q, rs_ok ? rs[PTR_W-1:0] : '0);
   assign pix_left = left_edge[pix_addr];

   assign bot_ok   = {1'b0, bot_row} < ROWS_B;
   assign bot_addr = ring_add(top_ptr_q, bot_ok ? bot_row : '0);
   assign bot_left = left_edge[bot_addr];

   assign unused_bits = ^{rand_val[7:2], pixel_column[1:0]};

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      top_ptr_d    = top_ptr_q;
      gap_d        = gap_q;
      frame_cnt_d  = frame_cnt_q;
      narrow_cnt_d = narrow_cnt_q;
      ready_d      = ready_q;
      mem_we       = 1'b0;
      mem_waddr    = init_idx_q;
      mem_wdata    = INIT_LEFT;
      tick         = 1'b0;

      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            if (init_idx_q == LAST_ROW) begin
               init_idx_d = '0;
               top_ptr_d  = '0;
               gap_d      = GAP_INIT;
               ready_d    = 1'b1;
               state_d    = ST_RUN;
            end else begin
               init_idx_d = init_idx_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (frame_end_q && scroll_en) begin
               if (frame_cnt_q == (2'd3 - speed)) begin
                  frame_cnt_d = '0;
                  state_d     = ST_STEP;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         ST_STEP: begin
            tick      = 1'b1;
            top_ptr_d = top_dec;
            mem_we    = 1'b1;
            mem_waddr = top_dec;
            mem_wdata = step_val;
            if (narrow_cnt_q == NARROW_LAST) begin
               narrow_cnt_d = '0;
               if (gap_q > GAP_MIN) begin
                  gap_d = gap_q - 1'b1;
               end
            end else begin
               narrow_cnt_d = narrow_cnt_q + 1'b1;
            end
            state_d = ST_RUN;
         end
         default: state_d = ST_INIT;
      endcase

      // Restart overrides everything, including a step in flight.
      if (restart) begin
         state_d      = ST_INIT;
         ready_d      = 1'b0;
         init_idx_d   = '0;
         frame_cnt_d  = '0;
         narrow_cnt_d = '0;
         top_ptr_d    = top_ptr_q;
         gap_d        = gap_q;
         mem_we       = 1'b0;
         tick         = 1'b0;
      end
   end

   always_comb begin
      wall_d = 2'b00;
      if (video_on) begin
         if (state_q == ST_INIT) begin
            wall_d = 2'b01;
         end else if (rs_ok) begin
            wall_d = classify(cs, pix_left, gap_q);
         end
      end
      collide_d = ready_q && bot_ok && (classify(bot_col, bot_left, gap_q) != 2'b00);
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         left_edge[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         top_ptr_q    <= '0;
         gap_q        <= GAP_INIT;
         frame_cnt_q  <= '0;
         narrow_cnt_q <= '0;
         ready_q      <= 1'b0;
         row_prev_q   <= '0;
         frame_end_q  <= 1'b0;
         wall_q       <= 2'b00;
         collide_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         top_ptr_q    <= top_ptr_d;
         gap_q        <= gap_d;
         frame_cnt_q  <= frame_cnt_d;
         narrow_cnt_q <= narrow_cnt_d;
         ready_q      <= ready_d;
         row_prev_q   <= pixel_row;
         frame_end_q  <= (row_prev_q == 10'd479) && (pixel_row == 10'd480);
         wall_q       <= wall_d;
         collide_q    <= collide_d;
      end
   end

   assign wall        = wall_q;
   assign collide     = collide_q;
   assign ready       = ready_q;
   assign scroll_tick = tick;

endmodule

// File: tb/tb_tunnel_wall_gen.sv
// Directed bench for tunnel_wall_gen: init timing, edge classification, scrolling,
// speed/hold, clamping, gap narrowing floor, collision, restart and async reset.
module tb_tunnel_wall_gen;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] pixel_row = '0;
   logic [9:0] pixel_column = '0;
   logic       video_on = 1'b0;
   logic [7:0] rand_val = '0;
   logic       scroll_en = 1'b0;
   logic [1:0] speed = '0;
   logic       restart = 1'b0;
   logic [6:0] bot_row = '0;
   logic [7:0] bot_col = '0;
   logic [1:0] wall;
   logic       collide;
   logic       ready;
   logic       scroll_tick;

   int n_pass = 0;
   int n_total = 0;
   int tick_cnt = 0;

   always #20 clock = ~clock;

   tunnel_wall_gen dut (
      .clock       (clock),
      .rst         (rst),
      .pixel_row   (pixel_row),
      .pixel_column(pixel_column),
      .video_on    (video_on),
      .rand_val    (rand_val),
      .scroll_en   (scroll_en),
      .speed       (speed),
      .restart     (restart),
      .bot_row     (bot_row),
      .bot_col     (bot_col),
      .wall        (wall),
      .collide     (collide),
      .ready       (ready),
      .scroll_tick (scroll_tick)
   );

   always @(negedge clock) begin
      if (scroll_tick === 1'b1) tick_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Present a raw pixel, return the registered wall code one clock later.
   task automatic pix(input int prow, input int pcol, input logic vo, output logic [1:0] w);
      pixel_row    = 10'(prow);
      pixel_column = 10'(pcol);
      video_on     = vo;
      @(posedge clock);
      @(negedge clock);
      w = wall;
      @(posedge clock);
      #1;
      pixel_row = '0;
   endtask

   task automatic frame();
      pixel_row = 10'd479;
      cyc(1);
      pixel_row = 10'd480;
      cyc(1);
      pixel_row = 10'd0;
      cyc(4);
   endtask

   task automatic test_reset();
      bot_row = 7'd10;
      bot_col = 8'd10;
      pixel_row = 10'd160;
      pixel_column = 10'd320;
      video_on = 1'b1;
      cyc(3);
      n_total++; if (wall !== 2'b00) $display("FAIL reset_wall: got %b want 00", wall); else n_pass++;
      n_total++; if (collide !== 1'b0) $display("FAIL reset_collide: got %b want 0", collide); else n_pass++;
      n_total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
      n_total++; if (scroll_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", scroll_tick); else n_pass++;
      @(posedge clock);
      #1;
      rst = 1'b1;
      cyc(5);
      n_total++; if (wall !== 2'b01) $display("FAIL init_wall: got %b want 01", wall); else n_pass++;
      cyc(114);
      n_total++; if (ready !== 1'b0) $display("FAIL ready_early: got %b want 0 at cycle 119", ready); else n_pass++;
      n_total++; if (collide !== 1'b0) $display("FAIL collide_not_ready: got %b want 0", collide); else n_pass++;
      cyc(1);
      n_total++; if (ready !== 1'b1) $display("FAIL ready_rise: got %b want 1 at cycle 120", ready); else n_pass++;
      pixel_row = '0;
   endtask

   task automatic test_init_edges();
      logic [1:0] w;
      pix(160, 4*47, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL init_left_edge: got %b want 10", w); else n_pass++;
      pix(160, 4*48, 1'b1, w);
      n_total++; if (w !== 2'b00) $display("FAIL init_interior: got %b want 00", w); else n_pass++;
      pix(160, 4*112, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL init_right_edge: got %b want 10", w); else n_pass++;
      pix(160, 4*113, 1'b1, w);
      n_total++; if (w !== 2'b01) $display("FAIL init_right_wall: got %b want 01", w); else n_pass++;
      pix(160, 4*10, 1'b0, w);
      n_total++; if (w !== 2'b00) $display("FAIL blank_video_off: got %b want 00", w); else n_pass++;
      pix(480, 4*10, 1'b1, w);
      n_total++; if (w !== 2'b00) $display("FAIL row_out_of_range: got %b want 00", w); else n_pass++;
   endtask

   task automatic test_collide();
      bot_row = 7'd10;
      bot_col = 8'd10;
      cyc(1);
      n_total++; if (collide !== 1'b1) $display("FAIL collide_wall: got %b want 1", collide); else n_pass++;
      bot_col = 8'd80;
      cyc(1);
      n_total++; if (collide !== 1'b0) $display("FAIL collide_interior: got %b want 0", collide); else n_pass++;
      bot_col = 8'd112;
      cyc(1);
      n_total++; if (collide !== 1'b1) $display("FAIL collide_edge: got %b want 1", collide); else n_pass++;
      bot_col = 8'd80;
   endtask

   task automatic test_scroll_walk();
      logic [1:0] w;
      int t0;
      scroll_en = 1'b1;
      speed = 2'd3;
      rand_val = 8'h02;
      t0 = tick_cnt;
      repeat (3) frame();
      scroll_en = 1'b0;
      n_total++; if (tick_cnt - t0 !== 3) $display("FAIL walk_ticks: got %0d want 3", tick_cnt - t0); else n_pass++;
      pix(0, 4*50, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL walk_row0_edge: got %b want 10", w); else n_pass++;
      pix(0, 4*49, 1'b1, w);
      n_total++; if (w !== 2'b01) $display("FAIL walk_row0_wall: got %b want 01", w); else n_pass++;
      pix(4, 4*49, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL walk_row1_edge: got %b want 10", w); else n_pass++;
      pix(8, 4*48, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL walk_row2_edge: got %b want 10", w); else n_pass++;
      pix(12, 4*47, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL walk_row3_edge: got %b want 10", w); else n_pass++;
   endtask

   task automatic test_speed_hold();
      int t0;
      scroll_en = 1'b1;
      speed = 2'd0;
      rand_val = 8'h01;
      t0 = tick_cnt;
      repeat (3) frame();
      n_total++; if (tick_cnt - t0 !== 0) $display("FAIL speed0_three: got %0d want 0", tick_cnt - t0); else n_pass++;
      frame();
      n_total++; if (tick_cnt - t0 !== 1) $display("FAIL speed0_fourth: got %0d want 1", tick_cnt - t0); else n_pass++;
      repeat (2) frame();
      scroll_en = 1'b0;
      repeat (3) frame();
      n_total++; if (tick_cnt - t0 !== 1) $display("FAIL hold_no_tick: got %0d want 1", tick_cnt - t0); else n_pass++;
      scroll_en = 1'b1;
      frame();
      n_total++; if (tick_cnt - t0 !== 1) $display("FAIL hold_count_kept: got %0d want 1", tick_cnt - t0); else n_pass++;
      frame();
      n_total++; if (tick_cnt - t0 !== 2) $display("FAIL hold_resume_tick: got %0d want 2", tick_cnt - t0); else n_pass++;
      scroll_en = 1'b0;
   endtask

   task automatic test_restart_step();
      logic [1:0] w;
      int t0;
      scroll_en = 1'b1;
      speed = 2'd3;
      rand_val = 8'h02;
      t0 = tick_cnt;
      pixel_row = 10'd479;
      cyc(1);
      pixel_row = 10'd480;
      cyc(1);
      pixel_row = 10'd0;
      cyc(1);
      restart = 1'b1;
      #1;
      n_total++; if (scroll_tick !== 1'b0) $display("FAIL restart_tick_comb: got %b want 0", scroll_tick); else n_pass++;
      cyc(1);
      restart = 1'b0;
      scroll_en = 1'b0;
      n_total++; if (tick_cnt - t0 !== 0) $display("FAIL restart_discard_step: got %0d want 0", tick_cnt - t0); else n_pass++;
      n_total++; if (ready !== 1'b0) $display("FAIL restart_ready_low: got %b want 0", ready); else n_pass++;
      cyc(119);
      n_total++; if (ready !== 1'b0) $display("FAIL restart_ready_early: got %b want 0", ready); else n_pass++;
      cyc(1);
      n_total++; if (ready !== 1'b1) $display("FAIL restart_ready_rise: got %b want 1", ready); else n_pass++;
      pix(0, 4*47, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL restart_row0_edge: got %b want 10", w); else n_pass++;
      pix(0, 4*48, 1'b1, w);
      n_total++; if (w !== 2'b00) $display("FAIL restart_row0_interior: got %b want 00", w); else n_pass++;
      pix(8, 4*47, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL restart_row2_edge: got %b want 10", w); else n_pass++;
   endtask

   task automatic test_clamp_low();
      logic [1:0] w;
      int t0;
      scroll_en = 1'b1;
      speed = 2'd3;
      rand_val = 8'h00;
      t0 = tick_cnt;
      repeat (60) frame();
      scroll_en = 1'b0;
      n_total++; if (tick_cnt - t0 !== 60) $display("FAIL clamp_ticks: got %0d want 60", tick_cnt - t0); else n_pass++;
      pix(0, 0, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL clamp_row0_col0: got %b want 10", w); else n_pass++;
      pix(0, 4*1, 1'b1, w);
      n_total++; if (w !== 2'b00) $display("FAIL clamp_row0_col1: got %b want 00", w); else n_pass++;
      pix(0, 4*62, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL clamp_row0_right: got %b want 10", w); else n_pass++;
      pix(0, 4*63, 1'b1, w);
      n_total++; if (w !== 2'b01) $display("FAIL clamp_row0_rwall: got %b want 01", w); else n_pass++;
      pix(4*13, 0, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL clamp_row13_col0: got %b want 10", w); else n_pass++;
      pix(4*14, 4*1, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL clamp_row14_edge: got %b want 10", w); else n_pass++;
      pix(4*14, 0, 1'b1, w);
      n_total++; if (w !== 2'b01) $display("FAIL clamp_row14_wall: got %b want 01", w); else n_pass++;
   endtask

   task automatic test_narrow_floor();
      logic [1:0] w;
      int width;
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      cyc(121);
      n_total++; if (ready !== 1'b1) $display("FAIL narrow_reinit: got %b want 1", ready); else n_pass++;
      scroll_en = 1'b1;
      speed = 2'd3;
      rand_val = 8'h03;
      repeat (656) frame();
      scroll_en = 1'b0;
      width = 0;
      for (int c = 0; c < 160; c++) begin
         pix(0, 4*c, 1'b1, w);
         if (w === 2'b00) width++;
      end
      n_total++; if (width !== 24) $display("FAIL narrow_width: got %0d want 24", width); else n_pass++;
      pix(0, 4*47, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL narrow_left_edge: got %b want 10", w); else n_pass++;
      pix(0, 4*72, 1'b1, w);
      n_total++; if (w !== 2'b10) $display("FAIL narrow_right_edge: got %b want 10", w); else n_pass++;
      pix(0, 4*73, 1'b1, w);
      n_total++; if (w !== 2'b01) $display("FAIL narrow_right_wall: got %b want 01", w); else n_pass++;
   endtask

   task automatic test_async_reset();
      pixel_row = 10'd160;
      pixel_column = 10'd0;
      video_on = 1'b1;
      cyc(2);
      n_total++; if (wall !== 2'b01) $display("FAIL pre_async_wall: got %b want 01", wall); else n_pass++;
      #5;
      rst = 1'b0;
      #2;
      n_total++; if (ready !== 1'b0) $display("FAIL async_ready: got %b want 0", ready); else n_pass++;
      n_total++; if (wall !== 2'b00) $display("FAIL async_wall: got %b want 00", wall); else n_pass++;
      cyc(2);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_init_edges();
      test_collide();
      test_scroll_walk();
      test_speed_hold();
      test_restart_step();
      test_clamp_low();
      test_narrow_floor();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
